// File: rtl/elastic_merge_arbiter_pkg.sv
// Shared parameters and types for the PE fork/merge elastic-channel blocks.
package elastic_merge_arbiter_pkg;

    localparam int PE_DATA_WIDTH   = 32;
    localparam int NEIGHBOR_PE_NUM = 4;
    localparam int MERGE_NUM_INPUT = NEIGHBOR_PE_NUM;
    localparam int MERGE_SRC_WIDTH = (MERGE_NUM_INPUT > 1) ? $clog2(MERGE_NUM_INPUT) : 1;

    typedef struct packed {
        logic [PE_DATA_WIDTH-1:0] data;
        logic                     valid;
    } elastic_ch_t;

    // Round-robin successor of a granted index; never reaches n.
    function automatic int rr_next(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/elastic_merge_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_id_o,
    output logic         any_o
);

    logic [W:0] idx_s;

    // Walk from the farthest candidate back to ptr_i so the nearest request wins.
    always_comb begin
        grant_id_o = '0;
        idx_s      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr_i} + (W + 1)'(k);
            if (idx_s >= (W + 1)'(N)) begin
                idx_s = idx_s - (W + 1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (req_i[idx_s[W-1:0]]) begin
                grant_id_o = idx_s[W-1:0];
            end else begin
                grant_id_o = grant_id_o;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/elastic_merge_arbiter.sv
// Round-robin merge of NUM_INPUT elastic channels into one registered output stage.
module elastic_merge_arbiter
    import elastic_merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int NUM_INPUT  = MERGE_NUM_INPUT,
    parameter int SRC_WIDTH  = $clog2(NUM_INPUT)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] input_data,
    input  logic [NUM_INPUT-1:0]                 valid_input,
    output logic [NUM_INPUT-1:0]                 stop_input,
    output logic [DATA_WIDTH-1:0]                output_data,
    output logic [SRC_WIDTH-1:0]                 output_src,
    output logic                                 valid_output,
    input  logic                                 stop_output
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SRC_WIDTH-1:0]  out_src_q,   out_src_d;
    logic [SRC_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [SRC_WIDTH-1:0]  grant_id_s;
    logic                  any_req_s;
    logic                  can_accept_s;
    logic                  grant_vld_s;

    rr_priority_picker #(
        .N (NUM_INPUT),
        .W (SRC_WIDTH)
    ) u_picker (
        .req_i      (valid_input),
        .ptr_i      (rr_ptr_q),
        .grant_id_o (grant_id_s),
        .any_o      (any_req_s)
    );

    // Grant qualification and per-input backpressure; reset blocks every grant.
    always_comb begin
        can_accept_s = !out_valid_q || !stop_output;
        grant_vld_s  = any_req_s && can_accept_s && !reset;
        for (int i = 0; i < NUM_INPUT; i++) begin
            stop_input[i] = !(grant_vld_s && (grant_id_s == SRC_WIDTH'(i)));
        end
    end

    // Next state of output stage and pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld_s) begin
            out_valid_d = 1'b1;
            out_data_d  = input_data[grant_id_s];
            out_src_d   = grant_id_s;
            rr_ptr_d    = SRC_WIDTH'(rr_next(int'(grant_id_s), NUM_INPUT));
        end else if (!stop_output) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset drops any word still held in the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign valid_output = out_valid_q;
    assign output_data  = out_data_q;
    assign output_src   = out_src_q;

endmodule

// File: tb/tb_elastic_merge_arbiter.sv
// Directed and randomized bench for elastic_merge_arbiter with an in-order scoreboard.
module tb_elastic_merge_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic                 clk;
    logic                 reset;
    logic [N-1:0][DW-1:0] input_data;
    logic [N-1:0]         valid_input;
    logic [N-1:0]         stop_input;
    logic [DW-1:0]        output_data;
    logic [1:0]           output_src;
    logic                 valid_output;
    logic                 stop_output;

    elastic_merge_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_INPUT  (N),
        .SRC_WIDTH  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .valid_input  (valid_input),
        .stop_input   (stop_input),
        .output_data  (output_data),
        .output_src   (output_src),
        .valid_output (valid_output),
        .stop_output  (stop_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_vld;
    logic [DW-1:0] m_data;
    logic [1:0]  m_src;
    logic [1:0]  m_ptr;
    bit          m_gv;
    int          m_gid;
    int          wait_cnt[N];
    int          seq[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at negedge+1, update the model, advance to the next negedge.
    task automatic cycle();
        logic [N-1:0] exp_stop;
        exp_t e;
        #1;
        m_gv  = 1'b0;
        m_gid = 0;
        if (!reset && (!m_vld || !stop_output)) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % N;
                if (!m_gv && valid_input[idx]) begin
                    m_gv  = 1'b1;
                    m_gid = idx;
                end
            end
        end
        exp_stop = 4'hF;
        if (m_gv) exp_stop[m_gid] = 1'b0;
        check("stop_input", 64'(stop_input), 64'(exp_stop));
        check("valid_output", 64'(valid_output), 64'(m_vld));
        if (m_vld) begin
            check("output_data", 64'(output_data), 64'(m_data));
            check("output_src", 64'(output_src), 64'(m_src));
        end
        check("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
        if (!reset && valid_output && !stop_output) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_data", 64'(output_data), 64'(e.d));
                check("sb_src", 64'(output_src), 64'(e.s));
            end
        end
        if (m_gv) begin
            for (int i = 0; i < N; i++) begin
                if (i == m_gid) wait_cnt[i] = 0;
                else if (valid_input[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (valid_input[i]) check("fair_wait", 64'(wait_cnt[i] <= N - 1), 64'd1);
            end
        end
        if (reset) begin
            m_vld = 1'b0; m_data = '0; m_src = '0; m_ptr = '0;
            sb.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else if (m_gv) begin
            m_vld  = 1'b1;
            m_data = input_data[m_gid];
            m_src  = 2'(m_gid);
            m_ptr  = (m_gid == N - 1) ? 2'd0 : 2'(m_gid + 1);
            e.d = input_data[m_gid];
            e.s = 2'(m_gid);
            sb.push_back(e);
        end else if (!stop_output) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; valid_input = '0; stop_output = 1'b0;
        for (int i = 0; i < N; i++) begin
            input_data[i] = '0; wait_cnt[i] = 0; seq[i] = 0;
        end
        m_vld = 1'b0; m_data = '0; m_src = '0; m_ptr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        reset = 1'b0;

        // 1: word 0xAA stalled in output stage, then reset drops it.
        input_data[0] = 32'hAA; valid_input = 4'b0001; stop_output = 1'b1;
        cycle();
        valid_input = 4'b0000;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; stop_output = 1'b0;
        cycle();
        cycle();

        // 2: all inputs valid, free-flowing output.
        for (int i = 0; i < N; i++) input_data[i] = 32'h10 + 32'(i);
        valid_input = 4'b1111;
        repeat (8) cycle();
        valid_input = 4'b0000;
        cycle();

        // 3: only input 2, first with pointer 0 then with pointer 3 (wrap search).
        input_data[2] = 32'h55; valid_input = 4'b0100;
        cycle();
        check("ptr_after_2", 64'(dut.rr_ptr_q), 64'd3);
        cycle();
        valid_input = 4'b0000;
        cycle();

        // 4: output holds 0x11/src1, then stall with inputs 0 and 3 valid.
        input_data[1] = 32'h11; valid_input = 4'b0010;
        cycle();
        input_data[0] = 32'h30; input_data[3] = 32'h33;
        valid_input = 4'b1001; stop_output = 1'b1;
        repeat (5) cycle();
        check("stall_data", 64'(output_data), 64'h11);
        stop_output = 1'b0;
        cycle();
        valid_input = 4'b0001;
        cycle();
        valid_input = 4'b0000;
        cycle();

        // 5: grant input 3, idle three cycles, then input 1.
        input_data[3] = 32'h77; valid_input = 4'b1000;
        cycle();
        valid_input = 4'b0000;
        repeat (3) cycle();
        input_data[1] = 32'h99; valid_input = 4'b0010;
        cycle();
        valid_input = 4'b0000;
        cycle();

        // 6: randomized held-valid sources and random downstream stalls.
        for (int t = 0; t < 400; t++) begin
            stop_output = ($urandom_range(0, 3) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (!valid_input[i] || (m_gv && m_gid == i)) begin
                    valid_input[i] = 1'($urandom_range(0, 1));
                    if (valid_input[i]) begin
                        input_data[i] = {8'(i), 24'(seq[i])};
                        seq[i]++;
                    end
                end
            end
        end
        valid_input = 4'b0000; stop_output = 1'b0;
        repeat (3) cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
